// File: rtl/pic8259_pkg.sv
// Shared definitions for the 8259-style interrupt controller blocks.
package pic8259_pkg;

    localparam int LEVEL_WIDTH = 3;
    localparam int IRQ_COUNT   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACK1  = 2'd1,
        ST_WAIT2 = 2'd2,
        ST_ACK2  = 2'd3
    } ack_state_e;

    function automatic logic [IRQ_COUNT-1:0] level_to_onehot(input logic [LEVEL_WIDTH-1:0] lvl);
        logic [IRQ_COUNT-1:0] v;
        v      = '0;
        v[lvl] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/in_service_priority_encoder.sv
// Lowest-index-wins encoder: one-hot of the lowest set bit, its index, and an any-set flag.
module in_service_priority_encoder
    import pic8259_pkg::*;
(
    input  logic [IRQ_COUNT-1:0]   request,
    output logic [IRQ_COUNT-1:0]   lowest_onehot,
    output logic [LEVEL_WIDTH-1:0] lowest_index,
    output logic                   any_set
);

    always_comb begin
        // x & -x isolates the lowest set bit
        lowest_onehot = request & (~request + IRQ_COUNT'(1));
        any_set       = |request;
        lowest_index  = '0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (request[i]) begin
                lowest_index = LEVEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_acknowledge_control.sv
// INTA sequencing, in-service register and vector drive for an 8259-style controller.
module interrupt_acknowledge_control
    import pic8259_pkg::*;
#(
    parameter logic [LEVEL_WIDTH-1:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [IRQ_COUNT-1:0]             interrupt,
    input  logic                             interrupt_acknowledge_n,
    input  logic                             end_of_interrupt,
    input  logic                             specific_eoi,
    input  logic [LEVEL_WIDTH-1:0]           eoi_level,
    input  logic                             auto_eoi,
    input  logic [IRQ_COUNT-LEVEL_WIDTH-1:0] interrupt_vector_base,
    output logic                             interrupt_to_cpu,
    output logic [IRQ_COUNT-1:0]             in_service_register,
    output logic [IRQ_COUNT-1:0]             highest_level_in_service,
    output logic [IRQ_COUNT-1:0]             clear_interrupt_request,
    output logic [IRQ_COUNT-1:0]             data_out,
    output logic                             data_out_enable
);

    ack_state_e             state_q, state_d;
    logic                   inta_q;
    logic [LEVEL_WIDTH-1:0] level_q, level_d;
    logic                   spurious_q, spurious_d;
    logic                   int_q, int_d;
    logic [IRQ_COUNT-1:0]   isr_q, isr_d;
    logic [IRQ_COUNT-1:0]   clr_q, clr_d;
    logic [IRQ_COUNT-1:0]   dout_q, dout_d;
    logic                   doe_q, doe_d;

    logic                   inta_fall, inta_rise;
    logic [IRQ_COUNT-1:0]   irq_onehot, isr_onehot;
    logic [LEVEL_WIDTH-1:0] irq_index, isr_index;
    logic                   irq_any, isr_any;
    logic [IRQ_COUNT-1:0]   isr_after_eoi, isr_set, isr_aeoi_clr;

    in_service_priority_encoder u_irq_enc (
        .request       (interrupt),
        .lowest_onehot (irq_onehot),
        .lowest_index  (irq_index),
        .any_set       (irq_any)
    );

    in_service_priority_encoder u_isr_enc (
        .request       (isr_q),
        .lowest_onehot (isr_onehot),
        .lowest_index  (isr_index),
        .any_set       (isr_any)
    );

    assign inta_fall = inta_q & ~interrupt_acknowledge_n;
    assign inta_rise = ~inta_q & interrupt_acknowledge_n;

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        spurious_d   = spurious_q;
        int_d        = 1'b0;
        clr_d        = '0;
        dout_d       = dout_q;
        doe_d        = doe_q;
        isr_set      = '0;
        isr_aeoi_clr = '0;

        // EOI acts on the pre-update ISR; a same-cycle acknowledge set is ORed in afterwards
        isr_after_eoi = isr_q;
        if (end_of_interrupt) begin
            if (specific_eoi) begin
                isr_after_eoi = isr_q & ~level_to_onehot(eoi_level);
            end else if (isr_any) begin
                isr_after_eoi = isr_q & ~level_to_onehot(isr_index);
            end
        end

        case (state_q)
            ST_IDLE: begin
                int_d = irq_any;
                if (inta_fall) begin
                    state_d = ST_ACK1;
                    int_d   = 1'b0;
                    if (irq_any) begin
                        level_d    = irq_index;
                        spurious_d = 1'b0;
                        isr_set    = irq_onehot;
                        clr_d      = irq_onehot;
                    end else begin
                        level_d    = SPURIOUS_LEVEL;
                        spurious_d = 1'b1;
                    end
                end
            end
            ST_ACK1: begin
                if (inta_rise) begin
                    state_d = ST_WAIT2;
                end
            end
            ST_WAIT2: begin
                if (inta_fall) begin
                    state_d = ST_ACK2;
                    dout_d  = {interrupt_vector_base, level_q};
                    doe_d   = 1'b1;
                end
            end
            ST_ACK2: begin
                // Vector stays on the bus through the cycle in which INTA# rise is seen
                if (inta_rise) begin
                    state_d = ST_IDLE;
                    dout_d  = '0;
                    doe_d   = 1'b0;
                    if (auto_eoi && !spurious_q) begin
                        isr_aeoi_clr = level_to_onehot(level_q);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        isr_d = (isr_after_eoi | isr_set) & ~isr_aeoi_clr;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            inta_q     <= 1'b1;
            level_q    <= '0;
            spurious_q <= 1'b0;
            int_q      <= 1'b0;
            isr_q      <= '0;
            clr_q      <= '0;
            dout_q     <= '0;
            doe_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inta_q     <= interrupt_acknowledge_n;
            level_q    <= level_d;
            spurious_q <= spurious_d;
            int_q      <= int_d;
            isr_q      <= isr_d;
            clr_q      <= clr_d;
            dout_q     <= dout_d;
            doe_q      <= doe_d;
        end
    end

    assign interrupt_to_cpu         = int_q;
    assign in_service_register      = isr_q;
    assign highest_level_in_service = isr_onehot;
    assign clear_interrupt_request  = clr_q;
    assign data_out                 = dout_q;
    assign data_out_enable          = doe_q;

endmodule

// File: tb/tb_interrupt_acknowledge_control.sv
// Directed bench: expected clear pulses and vectors are queued by the stimulus, popped by monitors.
module tb_interrupt_acknowledge_control;

    logic       clock;
    logic       reset_n;
    logic [7:0] interrupt;
    logic       interrupt_acknowledge_n;
    logic       end_of_interrupt;
    logic       specific_eoi;
    logic [2:0] eoi_level;
    logic       auto_eoi;
    logic [4:0] interrupt_vector_base;
    logic       interrupt_to_cpu;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [7:0] clear_interrupt_request;
    logic [7:0] data_out;
    logic       data_out_enable;

    logic [7:0] clr_exp_q[$];
    logic [7:0] vec_exp_q[$];
    int         checks;
    int         errors;

    interrupt_acknowledge_control dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .interrupt                (interrupt),
        .interrupt_acknowledge_n  (interrupt_acknowledge_n),
        .end_of_interrupt         (end_of_interrupt),
        .specific_eoi             (specific_eoi),
        .eoi_level                (eoi_level),
        .auto_eoi                 (auto_eoi),
        .interrupt_vector_base    (interrupt_vector_base),
        .interrupt_to_cpu         (interrupt_to_cpu),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .clear_interrupt_request  (clear_interrupt_request),
        .data_out                 (data_out),
        .data_out_enable          (data_out_enable)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // scoreboard monitors
    always @(negedge clock) begin
        if (clear_interrupt_request != 8'h00) begin
            if (clr_exp_q.size() == 0) begin
                check("unexpected_clear", clear_interrupt_request, 8'h00);
            end else begin
                check("clear_pulse", clear_interrupt_request, clr_exp_q.pop_front());
            end
        end
    end

    logic       vec_active = 1'b0;
    logic [7:0] cur_vec    = 8'h00;
    int         vec_len    = 0;
    always @(negedge clock) begin
        if (data_out_enable) begin
            if (!vec_active) begin
                vec_active = 1'b1;
                vec_len    = 0;
                if (vec_exp_q.size() == 0) begin
                    check("unexpected_vector", data_out, 8'h00);
                    cur_vec = 8'h00;
                end else begin
                    cur_vec = vec_exp_q.pop_front();
                end
            end
            vec_len++;
            check("vector", data_out, cur_vec);
        end else if (vec_active) begin
            vec_active = 1'b0;
            check("vector_cycles", 8'(vec_len), 8'd2);
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_outputs_reset(input string tag);
        check({tag, "_int"}, {7'b0, interrupt_to_cpu}, 8'h00);
        check({tag, "_isr"}, in_service_register, 8'h00);
        check({tag, "_hlis"}, highest_level_in_service, 8'h00);
        check({tag, "_clr"}, clear_interrupt_request, 8'h00);
        check({tag, "_dout"}, data_out, 8'h00);
        check({tag, "_doe"}, {7'b0, data_out_enable}, 8'h00);
    endtask

    task automatic do_reset();
        reset_n                 = 1'b0;
        interrupt               = 8'h00;
        interrupt_acknowledge_n = 1'b1;
        end_of_interrupt        = 1'b0;
        specific_eoi            = 1'b0;
        eoi_level               = 3'd0;
        auto_eoi                = 1'b0;
        interrupt_vector_base   = 5'b01000;
        tick(2);
        check_outputs_reset("reset");
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_clr_pending"}, 8'(clr_exp_q.size()), 8'd0);
        check({tag, "_vec_pending"}, 8'(vec_exp_q.size()), 8'd0);
    endtask

    task automatic ack_sequence(input logic [7:0] irq, input logic [7:0] exp_clr,
                                input logic [7:0] exp_vec, input logic [7:0] exp_isr_mid,
                                input logic [7:0] exp_isr_end, input logic eoi_at_fall,
                                input logic [2:0] eoi_lvl);
        interrupt = irq;
        tick(1);
        check("int_before_ack", {7'b0, interrupt_to_cpu}, {7'b0, irq != 8'h00});
        if (exp_clr != 8'h00) clr_exp_q.push_back(exp_clr);
        vec_exp_q.push_back(exp_vec);
        interrupt_acknowledge_n = 1'b0;
        if (eoi_at_fall) begin
            end_of_interrupt = 1'b1;
            specific_eoi     = 1'b1;
            eoi_level        = eoi_lvl;
        end
        tick(1);
        end_of_interrupt = 1'b0;
        specific_eoi     = 1'b0;
        interrupt        = 8'h00;
        check("isr_after_first_fall", in_service_register, exp_isr_mid);
        check("int_after_first_fall", {7'b0, interrupt_to_cpu}, 8'h00);
        tick(1);
        interrupt_acknowledge_n = 1'b1;
        tick(2);
        interrupt_acknowledge_n = 1'b0;
        tick(2);
        interrupt_acknowledge_n = 1'b1;
        tick(2);
        check("isr_after_second_rise", in_service_register, exp_isr_end);
    endtask

    task automatic eoi_cmd(input logic spec, input logic [2:0] lvl);
        end_of_interrupt = 1'b1;
        specific_eoi     = spec;
        eoi_level        = lvl;
        tick(1);
        end_of_interrupt = 1'b0;
        specific_eoi     = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // basic acknowledge of IRQ4, vector 0x44
        do_reset();
        interrupt = 8'b00010000;
        #3;
        check("int_latency_0", {7'b0, interrupt_to_cpu}, 8'h00);
        ack_sequence(8'b00010000, 8'b00010000, 8'h44, 8'b00010000, 8'b00010000, 1'b0, 3'd0);
        check("hlis_irq4", highest_level_in_service, 8'b00010000);
        check("doe_idle", {7'b0, data_out_enable}, 8'h00);
        check_drained("basic");

        // same with auto-EOI
        do_reset();
        auto_eoi = 1'b1;
        ack_sequence(8'b00010000, 8'b00010000, 8'h44, 8'b00010000, 8'h00, 1'b0, 3'd0);
        check_drained("aeoi");

        // build ISR = 10010001, then EOIs
        do_reset();
        ack_sequence(8'b00000001, 8'b00000001, 8'h40, 8'b00000001, 8'b00000001, 1'b0, 3'd0);
        ack_sequence(8'b10000000, 8'b10000000, 8'h47, 8'b10000001, 8'b10000001, 1'b0, 3'd0);
        ack_sequence(8'b00010000, 8'b00010000, 8'h44, 8'b10010001, 8'b10010001, 1'b0, 3'd0);
        check("hlis_three", highest_level_in_service, 8'b00000001);
        eoi_cmd(1'b0, 3'd5);
        check("isr_nseoi", in_service_register, 8'b10010000);
        check("hlis_nseoi", highest_level_in_service, 8'b00010000);
        eoi_cmd(1'b1, 3'd7);
        check("isr_seoi7", in_service_register, 8'b00010000);
        check("hlis_seoi7", highest_level_in_service, 8'b00010000);
        eoi_cmd(1'b0, 3'd0);
        check("isr_nseoi_last", in_service_register, 8'h00);
        eoi_cmd(1'b0, 3'd0);
        check("isr_nseoi_empty", in_service_register, 8'h00);
        check("hlis_empty", highest_level_in_service, 8'h00);
        check_drained("eoi");

        // spurious acknowledge with ISR[7] already set and auto-EOI on
        do_reset();
        ack_sequence(8'b10000000, 8'b10000000, 8'h47, 8'b10000000, 8'b10000000, 1'b0, 3'd0);
        auto_eoi  = 1'b1;
        interrupt = 8'b00010000;
        tick(1);
        check("int_spur_up", {7'b0, interrupt_to_cpu}, 8'h01);
        ack_sequence(8'h00, 8'h00, 8'h47, 8'b10000000, 8'b10000000, 1'b0, 3'd0);
        check_drained("spurious");

        // acknowledge set of IRQ2 collides with specific EOI level 2
        do_reset();
        ack_sequence(8'b00000100, 8'b00000100, 8'h42, 8'b00000100, 8'b00000100, 1'b0, 3'd0);
        ack_sequence(8'b00000100, 8'b00000100, 8'h42, 8'b00000100, 8'b00000100, 1'b1, 3'd2);
        check_drained("collide");

        // reset during WAIT2 abandons the acknowledge
        do_reset();
        interrupt = 8'b00010000;
        tick(1);
        clr_exp_q.push_back(8'b00010000);
        interrupt_acknowledge_n = 1'b0;
        tick(1);
        interrupt = 8'h00;
        tick(1);
        interrupt_acknowledge_n = 1'b1;
        tick(2);
        check("isr_in_wait2", in_service_register, 8'b00010000);
        reset_n = 1'b0;
        #1;
        check_outputs_reset("async_reset");
        tick(1);
        reset_n = 1'b1;
        tick(2);
        interrupt_acknowledge_n = 1'b0;
        tick(2);
        interrupt_acknowledge_n = 1'b1;
        tick(4);
        check("isr_after_single_pulse", in_service_register, 8'h00);
        check("doe_after_single_pulse", {7'b0, data_out_enable}, 8'h00);
        check_drained("reset_mid");

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interrupt_acknowledge_control.md
INTERRUPT_ACKNOWLEDGE_CONTROL -- requirements
Module: interrupt_acknowledge_control

Interface
REQ-001 SHALL have parameter SPURIOUS_LEVEL, default 3'd7, level used when first INTA finds no request.
REQ-002 SHALL have port clock  input  1  rising-edge clock; one clock domain.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port interrupt  input  8  one-hot winning request from the priority resolver; 0 = none.
REQ-005 SHALL have port interrupt_acknowledge_n  input  1  CPU INTA#, already synchronous to clock.
REQ-006 SHALL have port end_of_interrupt  input  1  one-cycle EOI command strobe.
REQ-007 SHALL have port specific_eoi  input  1  qualifies EOI: 1 = specific, 0 = non-specific.
REQ-008 SHALL have port eoi_level  input  3  level cleared by a specific EOI.
REQ-009 SHALL have port auto_eoi  input  1  AEOI mode enable.
REQ-010 SHALL have port interrupt_vector_base  input  5  ICW2 bits T7..T3.
REQ-011 SHALL have port interrupt_to_cpu  output  1  INT to CPU, registered.
REQ-012 SHALL have port in_service_register  output  8  ISR, feeds the resolver.
REQ-013 SHALL have port highest_level_in_service  output  8  one-hot lowest-index set ISR bit; 0 if ISR empty; feeds the resolver.
REQ-014 SHALL have port clear_interrupt_request  output  8  one-cycle pulse clearing the acknowledged IRR bit.
REQ-015 SHALL have ports data_out  output  8 and data_out_enable  output  1  vector byte and drive enable.

Function
REQ-016 SHALL detect INTA falling and rising edges from a one-cycle-delayed copy of interrupt_acknowledge_n.
REQ-017 SHALL implement FSM IDLE -> ACK1 (first INTA fall) -> WAIT2 (first INTA rise) -> ACK2 (second INTA fall) -> IDLE (second INTA rise).
REQ-018 SHALL in IDLE drive interrupt_to_cpu = (interrupt != 0), registered, one clock latency.
REQ-019 SHALL on first INTA fall latch level = encode(interrupt), or SPURIOUS_LEVEL if interrupt == 0, and deassert interrupt_to_cpu the next cycle.
REQ-020 SHALL on first INTA fall with nonzero interrupt set ISR[level] and pulse clear_interrupt_request[level] for exactly one cycle.
REQ-021 SHALL on first INTA fall with interrupt == 0 set no ISR bit and pulse no clear bit.
REQ-022 SHALL hold data_out_enable = 0 in IDLE, ACK1 and WAIT2.
REQ-023 SHALL in ACK2 drive data_out = {interrupt_vector_base, level} with data_out_enable = 1, from the cycle after the fall to the cycle of the rise.
REQ-024 SHALL, when auto_eoi = 1, clear ISR[level] on the second INTA rise, except for a spurious acknowledge.
REQ-025 SHALL, on non-specific EOI, clear the lowest-index set ISR bit; no effect if ISR == 0.
REQ-026 SHALL, on specific EOI, clear ISR[eoi_level] regardless of other bits.
REQ-027 SHALL, on simultaneous EOI and ISR set in one cycle, apply the clear to the pre-update ISR, then OR in the set bit; the set wins on the same bit.
REQ-028 SHALL ignore INTA edges not matching the current state (e.g. a rise in IDLE).
REQ-029 SHALL ignore interrupt changes while not in IDLE; the latched level is used.
REQ-030 SHALL update highest_level_in_service in the same cycle as ISR, as a combinational function of registered ISR.

Reset
REQ-031 SHALL on reset_n low asynchronously force FSM = IDLE, ISR = 0, latched level = 0, interrupt_to_cpu = 0, clear_interrupt_request = 0, data_out = 0, data_out_enable = 0, INTA delay register = 1.
REQ-032 SHALL on reset mid-sequence abandon the acknowledge; no vector is driven after release.

Structure
REQ-033 SHALL take the FSM state enum, LEVEL_WIDTH = 3 and IRQ_COUNT = 8 from shared package pic8259_pkg.
REQ-034 SHALL use one sub-module, in_service_priority_encoder (8-bit lowest-set-bit one-hot and index), for REQ-013, REQ-019 and REQ-025.

Verification
REQ-035 SHALL check: interrupt = 8'b00010000, base = 5'b01000, two INTA pulses -> INT rises 1 cycle later; ISR = 8'b00010000; clear pulse 8'b00010000 once; data_out = 8'h44 during second INTA only.
REQ-036 SHALL check: same as REQ-035 with auto_eoi = 1 -> ISR returns to 0 on second INTA rise.
REQ-037 SHALL check: ISR = 8'b10010001, non-specific EOI -> ISR = 8'b10010000, highest_level_in_service = 8'b00010000; then specific EOI level 7 -> ISR = 8'b00010000.
REQ-038 SHALL check: interrupt drops to 0 before first INTA fall, base 5'b01000 -> ISR unchanged, no clear pulse, data_out = 8'h47.
REQ-039 SHALL check: first INTA fall on IRQ2 in the same cycle as specific EOI level 2 with ISR[2] = 1 -> ISR[2] = 1 afterwards.
REQ-040 SHALL check: reset_n low during WAIT2 -> all outputs 0 immediately; a later single INTA pulse drives no vector.
